// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU, debug/loader) arbiter in front of one single-port data memory.
// Latency: combinational grant, memory access on the grant edge, rvalid/rdata/err one cycle later.
// Backpressure: the losing requester holds its request (cpu_stall); debug wins after STARVE_MAX contested CPU grants.
// Optional feature macro: DMEM_ARB_STATS_EN adds stat_cpu_cnt, stat_dbg_cnt and stat_conflict_cnt.
module dmem_arbiter #(
   parameter int unsigned DEPTH      = 2048,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   // CPU port
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   // debug / loader port
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        dbg_err,
   // memory side
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0] stat_cpu_cnt,
   output logic [31:0] stat_dbg_cnt,
   output logic [31:0] stat_conflict_cnt
`endif
);

   // Counter wide enough to hold STARVE_MAX itself (at least one bit).
   localparam int unsigned SW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [31:0]   DEPTH_W    = 32'(DEPTH);

   // Owner encoding for the response stage.
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   logic [SW-1:0] starve_q, starve_d;
   logic          rsp_own_q, rsp_own_d;   // which port owns next cycle's response
   logic          rsp_rd_q,  rsp_rd_d;    // granted access was a read
   logic          rsp_err_q, rsp_err_d;   // granted access was out of range

   logic          contested;
   logic          cpu_win;
   logic          cpu_gnt_c;
   logic          dbg_gnt_c;
   logic          any_gnt;
   logic          sel_we;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic          in_range;
   logic          mem_access;

   // Arbitration: CPU has priority unless it has starved debug for STARVE_MAX contested grants.
   // Grants are forced low while reset is asserted so nothing reaches the memory.
   always_comb begin
      contested = cpu_req & dbg_req;
      cpu_win   = cpu_req & ~(dbg_req & (starve_q == STARVE_LIM));
      cpu_gnt_c = rst_n & cpu_win;
      dbg_gnt_c = rst_n & dbg_req & ~cpu_win;
      any_gnt   = cpu_gnt_c | dbg_gnt_c;
   end

   // Route the winning request to the memory; out-of-range accesses are granted but never touch it.
   always_comb begin
      sel_we     = dbg_gnt_c ? dbg_we    : cpu_we;
      sel_addr   = dbg_gnt_c ? dbg_addr  : cpu_addr;
      sel_wdata  = dbg_gnt_c ? dbg_wdata : cpu_wdata;
      in_range   = (sel_addr < DEPTH_W);
      mem_access = any_gnt & in_range;
      mem_we     = mem_access & sel_we;
      mem_re     = mem_access & ~sel_we;
      mem_addr   = mem_access ? sel_addr : 32'd0;
      mem_wdata  = (mem_access & sel_we) ? sel_wdata : 32'd0;
   end

   assign cpu_gnt   = cpu_gnt_c;
   assign dbg_gnt   = dbg_gnt_c;
   assign cpu_stall = cpu_req & ~cpu_gnt_c;

   // Starvation counter: count contested CPU wins, saturate, clear on any debug grant.
   always_comb begin
      starve_d = starve_q;
      if (dbg_gnt_c) begin
         starve_d = '0;
      end else if (cpu_gnt_c & contested & (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Response stage inputs: capture owner, kind and range status of this cycle's grant.
   always_comb begin
      rsp_own_d = dbg_gnt_c ? OWN_DBG : OWN_CPU;
      rsp_rd_d  = any_gnt & ~sel_we;
      rsp_err_d = any_gnt & ~in_range;
   end

   // State registers; reset drops any in-flight response so nothing surfaces after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q  <= '0;
         rsp_own_q <= OWN_CPU;
         rsp_rd_q  <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         starve_q  <= starve_d;
         rsp_own_q <= rsp_own_d;
         rsp_rd_q  <= rsp_rd_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Steer the memory's read data to the owning port; out-of-range reads return zero.
   always_comb begin
      cpu_rvalid = rsp_rd_q & (rsp_own_q == OWN_CPU);
      dbg_rvalid = rsp_rd_q & (rsp_own_q == OWN_DBG);
      cpu_err    = rsp_err_q & (rsp_own_q == OWN_CPU);
      dbg_err    = rsp_err_q & (rsp_own_q == OWN_DBG);
      cpu_rdata  = (cpu_rvalid & ~rsp_err_q) ? mem_rdata : 32'd0;
      dbg_rdata  = (dbg_rvalid & ~rsp_err_q) ? mem_rdata : 32'd0;
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_cpu_q,  stat_cpu_d;
   logic [31:0] stat_dbg_q,  stat_dbg_d;
   logic [31:0] stat_conf_q, stat_conf_d;

   // Free-running statistics, wrapping naturally at 2^32.
   always_comb begin
      stat_cpu_d  = stat_cpu_q  + {31'd0, cpu_gnt_c};
      stat_dbg_d  = stat_dbg_q  + {31'd0, dbg_gnt_c};
      stat_conf_d = stat_conf_q + {31'd0, contested};
   end

   // Statistics registers, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cpu_q  <= 32'd0;
         stat_dbg_q  <= 32'd0;
         stat_conf_q <= 32'd0;
      end else begin
         stat_cpu_q  <= stat_cpu_d;
         stat_dbg_q  <= stat_dbg_d;
         stat_conf_q <= stat_conf_d;
      end
   end

   assign stat_cpu_cnt      = stat_cpu_q;
   assign stat_dbg_cnt      = stat_dbg_q;
   assign stat_conflict_cnt = stat_conf_q;
`endif

endmodule
